// File: rtl/bit_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// bit_serial_adder_ctrl
//   Adds two WIDTH-bit operands plus a carry-in one bit per clock, LSB first,
//   through a single full_adder. A start in IDLE captures the operands. RUN
//   then takes WIDTH cycles, one result bit per cycle. The result appears in
//   sum/c_out on the RUN->DONE edge. DONE lasts one cycle, then the block
//   returns to IDLE.
//
//   Ports
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset
//     start  in   begin an addition (honoured in IDLE only)
//     a, b   in   WIDTH-bit operands, captured with an accepted start
//     c_in   in   carry-in, captured with an accepted start
//     busy   out  high while RUN
//     done   out  one-cycle pulse while DONE (new result valid)
//     sum    out  WIDTH-bit result of the last completed addition
//     c_out  out  carry-out of the last completed addition
// ---------------------------------------------------------------------------

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s_out,
  output logic c_out
);
  assign s_out = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module bit_serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             cy_q;
  // Only WIDTH-1 sum bits need storing: the final bit comes straight from
  // the adder on the completing edge.
  logic [WIDTH-2:0] ps_q, ps_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, full_d;
  logic             co_q, busy_q, done_q;
  logic             fa_s, fa_c;

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .c_in (cy_q),
    .s_out(fa_s),
    .c_out(fa_c)
  );

  // New bit enters at the MSB; after WIDTH shifts full_d holds the whole sum.
  always_comb begin
    full_d = {fa_s, ps_q};
    ps_d   = full_d[WIDTH-1:1];
    cnt_d  = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cy_q    <= 1'b0;
      ps_q    <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            cy_q    <= c_in;
            cnt_q   <= '0;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          cy_q  <= fa_c;
          ps_q  <= ps_d;
          cnt_q <= cnt_d;
          if (cnt_q == LAST) begin
            sum_q   <= full_d;
            co_q    <= fa_c;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = co_q;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
module tb_bit_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         c_in = 1'b0;
  logic         busy, done, c_out;
  logic [W-1:0] sum;

  bit_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Timeline model: edges counted while out of reset. An accepted start at
  // edge t0 means busy after edges t0..t0+W-1, done after edge t0+W, result
  // published at edge t0+W, next start honoured from edge t0+W+2.
  int           e       = 0;
  int           t0      = -1000;
  int           next_ok = 0;
  logic [W:0]   pend    = '0;
  logic [W:0]   m_res   = '0;

  always @(posedge clk) begin
    if (rst_n) begin
      e++;
      if (e == t0 + W) m_res = pend;
      if (start && e >= next_ok) begin
        t0      = e;
        pend    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};
        next_ok = e + W + 2;
      end
    end
  end

  always @(negedge rst_n) begin
    t0      = -1000;
    next_ok = 0;
    m_res   = '0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, (e >= t0 && e < t0 + W));
      chk("done", done, (e == t0 + W));
      chk("result", {c_out, sum}, m_res);
    end
  end

  // Issue one operation from IDLE (called at a negedge). Optionally re-raise
  // start with new operands 'extra' cycles later. Returns the result seen with
  // done and the number of busy cycles, and leaves the block in IDLE.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                       input int extra, output logic [W:0] r, output int bc);
    bit got;
    a = ia; b = ib; c_in = ic; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
    bc  = busy ? 1 : 0;
    got = 1'b0;
    r   = '0;
    for (int k = 1; k < 40 && !got; k++) begin
      start = (extra > 0 && k == extra);
      if (start) begin a = W'($urandom); b = W'($urandom); c_in = 1'($urandom); end
      @(negedge clk);
      if (done) begin got = 1'b1; r = {c_out, sum}; end
      else if (busy) bc++;
    end
    start = 1'b0;
    chk("done_seen", got, 1'b1);
    @(negedge clk);
  endtask

  logic [W:0] r;
  int         bc, nd;
  logic [W-1:0] ra, rb;
  logic         rc;

  initial begin
    // Reset state
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", {c_out, sum}, '0);
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Basic add with latency
    do_op(8'h5A, 8'h3C, 1'b0, 0, r, bc);
    chk("5A+3C", r, 9'h096);
    chk("5A+3C_busy_cycles", bc, 8);

    do_op(8'hFF, 8'h01, 1'b0, 0, r, bc);
    chk("FF+01", r, 9'h100);
    do_op(8'hFF, 8'hFF, 1'b1, 0, r, bc);
    chk("FF+FF+1", r, 9'h1FF);

    // Start held high: one op per W+2 cycles
    a = 8'h01; b = 8'h01; c_in = 1'b0; start = 1'b1;
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin nd++; chk("held_sum", {c_out, sum}, 9'h002); end
    end
    start = 1'b0;
    chk("held_done_count", nd, 4);
    @(negedge clk);

    // Second start mid-RUN ignored
    do_op(8'h12, 8'h34, 1'b1, 3, r, bc);
    chk("restart_ignored", r, 9'h047);
    chk("restart_busy_cycles", bc, 8);

    // Reset mid-RUN
    a = 8'hAA; b = 8'h55; c_in = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_result", {c_out, sum}, '0);
    // start already pending so the first edge after release must accept it
    a = 8'h80; b = 8'h80; c_in = 1'b1; start = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_accept", busy, 1'b1);
    start = 1'b0;
    nd = 0;
    for (int k = 0; k < 20 && nd == 0; k++) begin
      @(negedge clk);
      if (done) begin nd++; chk("post_reset_sum", {c_out, sum}, 9'h101); end
    end
    chk("post_reset_done", nd, 1);
    @(negedge clk);

    // Random regression
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      do_op(ra, rb, rc, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 0, r, bc);
      if (r !== ({1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc}))
        chk("rand_sum", r, {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc});
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
